// File: rtl/snn_timestep_scheduler_if.sv
// Signal bundle between a host/neuron bank and snn_timestep_scheduler.
// clear_counts/spike_counts exist only when SCHED_SPIKE_COUNT_EN is defined.
interface snn_timestep_scheduler_if #(
  parameter int M         = 8,
  parameter int Nbits     = 4,
  parameter int N_NEURONS = 4,
  parameter int TS_W      = 16
);
  logic                 start;
  logic [M-1:0]         in_spikes;
  logic                 busy;
  logic                 done;
  logic                 neuron_enable;
  logic [M-1:0]         neuron_spikes;
  logic [N_NEURONS-1:0] neuron_spike_in;
  logic [N_NEURONS-1:0] out_spikes;
  logic [TS_W-1:0]      timestep;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [Nbits-1:0]     cfg_wdata;
  logic [Nbits-1:0]     threshold;
  logic [Nbits-1:0]     decay;
  logic [Nbits-1:0]     refractory_period;
`ifdef SCHED_SPIKE_COUNT_EN
  logic                     clear_counts;
  logic [N_NEURONS*8-1:0]   spike_counts;

  modport master (
    output start, in_spikes, neuron_spike_in, cfg_we, cfg_addr, cfg_wdata, clear_counts,
    input  busy, done, neuron_enable, neuron_spikes, out_spikes, timestep,
    input  threshold, decay, refractory_period, spike_counts
  );
  modport slave (
    input  start, in_spikes, neuron_spike_in, cfg_we, cfg_addr, cfg_wdata, clear_counts,
    output busy, done, neuron_enable, neuron_spikes, out_spikes, timestep,
    output threshold, decay, refractory_period, spike_counts
  );
`else
  modport master (
    output start, in_spikes, neuron_spike_in, cfg_we, cfg_addr, cfg_wdata,
    input  busy, done, neuron_enable, neuron_spikes, out_spikes, timestep,
    input  threshold, decay, refractory_period
  );
  modport slave (
    input  start, in_spikes, neuron_spike_in, cfg_we, cfg_addr, cfg_wdata,
    output busy, done, neuron_enable, neuron_spikes, out_spikes, timestep,
    output threshold, decay, refractory_period
  );
`endif
endinterface

// File: rtl/snn_timestep_scheduler.sv
// LIF timestep sequencer IDLE->LOAD->RUN->SETTLE->CAPTURE; done EN_CYCLES+SETTLE_CYCLES+2 edges after start.
// No backpressure (start sampled only in IDLE); SCHED_SPIKE_COUNT_EN adds per-neuron saturating spike counters.
module snn_timestep_scheduler #(
  parameter int M             = 8,
  parameter int Nbits         = 4,
  parameter int N_NEURONS     = 4,
  parameter int EN_CYCLES     = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int TS_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  snn_timestep_scheduler_if.slave  io_sch
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [3:0]       EN_LD     = 4'(EN_CYCLES - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  localparam logic [Nbits-1:0] THR_RST   = Nbits'(8);
  localparam logic [Nbits-1:0] DEC_RST   = Nbits'(1);
  localparam logic [Nbits-1:0] REF_RST   = Nbits'(2);

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic                 w_accept, w_busy, w_en, w_done;
  logic [M-1:0]         r_nspk;
  logic [N_NEURONS-1:0] r_out;
  logic [TS_W-1:0]      r_ts;
  logic [Nbits-1:0]     r_sh_thr, r_sh_dec, r_sh_ref;
  logic [Nbits-1:0]     w_sh_thr_nxt, w_sh_dec_nxt, w_sh_ref_nxt;
  logic [Nbits-1:0]     r_thr, r_dec, r_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One down-counter is shared by RUN and SETTLE; it is reloaded on each entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_busy      = 1'b1;
    w_en        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (io_sch.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = EN_LD;
      end
      S_RUN: begin
        w_en = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_CAPTURE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CAPTURE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A write landing on the accept cycle must reach the active copy, so it is forwarded here.
  always_comb begin
    w_sh_thr_nxt = r_sh_thr;
    w_sh_dec_nxt = r_sh_dec;
    w_sh_ref_nxt = r_sh_ref;
    if (io_sch.cfg_we) begin
      case (io_sch.cfg_addr)
        2'd0:    w_sh_thr_nxt = io_sch.cfg_wdata;
        2'd1:    w_sh_dec_nxt = io_sch.cfg_wdata;
        2'd2:    w_sh_ref_nxt = io_sch.cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_thr <= THR_RST;
      r_sh_dec <= DEC_RST;
      r_sh_ref <= REF_RST;
      r_thr    <= THR_RST;
      r_dec    <= DEC_RST;
      r_ref    <= REF_RST;
    end else begin
      r_sh_thr <= w_sh_thr_nxt;
      r_sh_dec <= w_sh_dec_nxt;
      r_sh_ref <= w_sh_ref_nxt;
      if (w_accept) begin
        r_thr <= w_sh_thr_nxt;
        r_dec <= w_sh_dec_nxt;
        r_ref <= w_sh_ref_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nspk <= '0;
      r_out  <= '0;
      r_ts   <= '0;
    end else begin
      if (w_accept) r_nspk <= io_sch.in_spikes;
      if (r_state == S_CAPTURE) begin
        r_out <= io_sch.neuron_spike_in;
        r_ts  <= r_ts + TS_W'(1);
      end
    end
  end

`ifdef SCHED_SPIKE_COUNT_EN
  logic [N_NEURONS-1:0][7:0] r_spk_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spk_cnt <= '0;
    end else if (io_sch.clear_counts) begin
      r_spk_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (io_sch.neuron_spike_in[n] && (r_spk_cnt[n] != 8'hFF))
          r_spk_cnt[n] <= r_spk_cnt[n] + 8'd1;
      end
    end
  end

  assign io_sch.spike_counts = r_spk_cnt;
`endif

  assign io_sch.busy              = w_busy;
  assign io_sch.done              = w_done;
  assign io_sch.neuron_enable     = w_en;
  assign io_sch.neuron_spikes     = r_nspk;
  assign io_sch.out_spikes        = r_out;
  assign io_sch.timestep          = r_ts;
  assign io_sch.threshold         = r_thr;
  assign io_sch.decay             = r_dec;
  assign io_sch.refractory_period = r_ref;
endmodule
